decode_stage: RTL

//  Registered, handshaked RV32I decode stage for the pipelined core; sits between fetch and execute.

---
 rtl/decode_stage.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes one instruction per handshake into a registered bundle,
// with a one-entry skid buffer so in_ready comes straight from a flop.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [2:0]       funct3,
    output logic             funct7b5,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             pc_src_a,
    output logic             lui,
    output logic             branch,
    output logic             jump,
    output logic             jalr,
    output logic             mem_read,
    output logic             mem_write,
    output logic             memtoreg,
    output logic             write_enable,
    output logic [XLEN-1:0]  immediate,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_count,
    output logic [CNT_W-1:0] ill_count
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [1:0]      alu_op;
        logic            alu_src;
        logic            pc_src_a;
        logic            lui;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic            mem_read;
        logic            mem_write;
        logic            memtoreg;
        logic            we;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundle_t;

    function automatic bundle_t decode_instr(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        bundle_t            b;
        logic signed [31:0] imm32;
        b          = '0;
        imm32      = '0;
        b.pc       = pc;
        b.rs1      = ins[19:15];
        b.rs2      = ins[24:20];
        b.rd       = ins[11:7];
        b.funct3   = ins[14:12];
        b.funct7b5 = ins[30];
        case (ins[6:0])
            7'b0110011: begin // OP
                b.we = 1'b1; b.alu_op = 2'b10;
            end
            7'b0010011: begin // OP-IMM
                b.we = 1'b1; b.alu_src = 1'b1; b.alu_op = 2'b11;
                imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0000011: begin // LOAD
                b.we = 1'b1; b.alu_src = 1'b1; b.mem_read = 1'b1; b.memtoreg = 1'b1;
                imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin // STORE
                b.alu_src = 1'b1; b.mem_write = 1'b1;
                imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin // BRANCH
                b.branch = 1'b1; b.alu_op = 2'b01;
                imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111: begin // LUI
                b.we = 1'b1; b.alu_src = 1'b1; b.lui = 1'b1;
                imm32 = {ins[31:12], 12'b0};
            end
            7'b0010111: begin // AUIPC
                b.we = 1'b1; b.alu_src = 1'b1; b.pc_src_a = 1'b1;
                imm32 = {ins[31:12], 12'b0};
            end
            7'b1101111: begin // JAL
                b.we = 1'b1; b.jump = 1'b1; b.pc_src_a = 1'b1;
                imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b1100111: begin // JALR
                b.we = 1'b1; b.jump = 1'b1; b.jalr = 1'b1; b.alu_src = 1'b1;
                imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            default: b.illegal = 1'b1;
        endcase
        if (ins[11:7] == 5'd0) begin
            b.we = 1'b0;
        end
        b.imm = XLEN'(imm32);
        return b;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        if (en && (cnt != {CNT_W{1'b1}})) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

    bundle_t          out_q, out_d, skid_q, skid_d, dec_b;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d, ill_cnt_q, ill_cnt_d;
    logic             in_fire, out_fire;

    always_comb begin
        dec_b        = decode_instr(instr, in_pc);
        in_fire      = in_valid & ~skid_valid_q;
        out_fire     = out_valid_q & out_ready;
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output register free this cycle: skid first to preserve order.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_d = dec_b;
                end
            end
        end else if (in_fire) begin
            skid_d       = dec_b;
            skid_valid_d = 1'b1;
        end
        dec_cnt_d = sat_inc(dec_cnt_q, out_fire);
        ill_cnt_d = sat_inc(ill_cnt_q, out_fire & out_q.illegal);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            dec_cnt_q    <= '0;
            ill_cnt_q    <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            dec_cnt_q    <= dec_cnt_d;
            ill_cnt_q    <= ill_cnt_d;
        end
    end

    assign in_ready     = ~skid_valid_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = out_q.pc;
    assign rs1          = out_q.rs1;
    assign rs2          = out_q.rs2;
    assign rd           = out_q.rd;
    assign funct3       = out_q.funct3;
    assign funct7b5     = out_q.funct7b5;
    assign alu_op       = out_q.alu_op;
    assign alu_src      = out_q.alu_src;
    assign pc_src_a     = out_q.pc_src_a;
    assign lui          = out_q.lui;
    assign branch       = out_q.branch;
    assign jump         = out_q.jump;
    assign jalr         = out_q.jalr;
    assign mem_read     = out_q.mem_read;
    assign mem_write    = out_q.mem_write;
    assign memtoreg     = out_q.memtoreg;
    assign write_enable = out_q.we;
    assign immediate    = out_q.imm;
    assign illegal      = out_q.illegal;
    assign dec_count    = dec_cnt_q;
    assign ill_count    = ill_cnt_q;

endmodule
